// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: controller states and the
// per-branch record held while a prediction is in flight.
package branch_pkg;

    localparam int unsigned IDX_W_DEFAULT = 5;
    // Entries carry the widest supported index; narrower builds zero-extend.
    localparam int unsigned IDX_MAX_W     = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 pred_taken;
    } entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of outstanding predictions. A clear wins over any
// push or pop in the same cycle.
module pred_fifo
    import branch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  entry_t         push_data_i,
    input  logic           pop_i,
    input  logic           clear_i,
    output entry_t         head_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] occupancy_o
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o      = (count_q == DEPTH_CNT);
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;

    // NOTE: the storage is reset along with the pointers so a stale head
    // can never leak onto the update port after reset; it is only a few flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches in program order, checks them against execute
// outcomes, drives the history-table update port and flushes on mispredict.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = IDX_W_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_idx,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_addr,
    output logic             upd_taken,
    output logic             mispredict,
    output logic             res_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    state_e           state_q, state_d;
    entry_t           push_entry;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   occupancy;
    logic             run;
    logic             push;
    logic             pop;
    logic             mismatch;
    logic             err_set;

    logic             upd_valid_q;
    logic [IDX_W-1:0] upd_addr_q;
    logic             upd_taken_q;
    logic             mispredict_q;
    logic             res_err_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    assign run        = (state_q == ST_RUN);
    assign pred_ready = run && !fifo_full;
    assign push       = pred_valid && pred_ready;
    // Emptiness is judged on registered occupancy, so a branch pushed this
    // cycle cannot be resolved until the next one.
    assign pop        = res_valid && run && !fifo_empty;
    assign err_set    = res_valid && run && (occupancy == '0);
    assign mismatch   = pop && (head.pred_taken != res_taken);
    assign push_entry = '{idx: IDX_MAX_W'(pred_idx), pred_taken: pred_taken};

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .clear_i     (mismatch),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (mismatch) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            res_err_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_valid_q  <= pop;
            mispredict_q <= mismatch;
            if (pop) begin
                upd_addr_q  <= IDX_W'(head.idx);
                upd_taken_q <= res_taken;
            end
            if (err_set) res_err_q <= 1'b1;
            if (pop && !(&branch_cnt_q))       branch_cnt_q  <= branch_cnt_q + 1'b1;
            if (mismatch && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_addr      = upd_addr_q;
    assign upd_taken     = upd_taken_q;
    assign mispredict    = mispredict_q;
    assign res_err       = res_err_q;
    assign branch_count  = branch_cnt_q;
    assign mispred_count = mispred_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight predicted branches tracked (power of two, 2..8).
REQ-002 Parameter IDX_W, default 5, width of the branch history table index.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  input  1  single clock for the block.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pred_valid  input  1  fetch issues a predicted branch this cycle.
REQ-007 pred_idx  input  IDX_W  table index (PC low bits) of the issued branch.
REQ-008 pred_taken  input  1  direction predicted by the history table.
REQ-009 pred_ready  output  1  block can accept a prediction this cycle.
REQ-010 res_valid  input  1  execute resolves the oldest outstanding branch.
REQ-011 res_taken  input  1  actual branch outcome.
REQ-012 upd_valid  output  1  write strobe to the history table update port.
REQ-013 upd_addr  output  IDX_W  history table index to update.
REQ-014 upd_taken  output  1  outcome fed to the table's saturating-counter update.
REQ-015 mispredict  output  1  one-cycle flush pulse to fetch.
REQ-016 res_err  output  1  sticky flag: resolution arrived with no outstanding branch.
REQ-017 branch_count  output  CNT_W  resolved branches.
REQ-018 mispred_count  output  CNT_W  mispredicted branches.

Function
REQ-019 Entries SHALL be held in program order in a FIFO of DEPTH entries of {idx, pred_taken}.
REQ-020 pred_ready SHALL be 1 iff state is RUN and occupancy < DEPTH; push occurs iff pred_valid && pred_ready.
REQ-021 With a full FIFO, a same-cycle pop SHALL NOT enable a push (no bypass).
REQ-022 Pop occurs iff res_valid, state RUN and FIFO non-empty at the cycle start; a same-cycle push SHALL NOT be resolvable in that cycle.
REQ-023 res_valid with an empty FIFO in RUN SHALL set res_err and be otherwise ignored; res_err clears only on reset.
REQ-024 One cycle after a pop, upd_valid SHALL pulse for one cycle with upd_addr = popped idx and upd_taken = res_taken.
REQ-025 mispredict SHALL pulse in that same cycle iff popped pred_taken != res_taken.
REQ-026 On a mismatching pop, all remaining entries and any same-cycle push SHALL be discarded (occupancy 0) and state SHALL go RUN -> FLUSH.
REQ-027 FLUSH SHALL last exactly one cycle with pred_ready = 0 and res_valid ignored (no res_err), then return to RUN.
REQ-028 States SHALL be RUN and FLUSH only; no other transitions exist.
REQ-029 branch_count SHALL increment per pop, mispred_count per mismatching pop, both saturating at all ones.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be a (log2(DEPTH)+1)-bit counter.

Reset
REQ-031 Asserting rst SHALL immediately clear FIFO, counters, res_err, upd_valid, upd_addr, upd_taken and mispredict to 0 and set state to RUN.
REQ-032 Reset mid-operation SHALL discard in-flight entries and any pending update; pred_ready SHALL read 1 from the first cycle after deassertion.

Structure
REQ-033 Package branch_pkg SHALL hold IDX_W default, the RUN/FLUSH state encoding and the {idx, pred_taken} entry type.
REQ-034 The FIFO SHALL be a sub-module pred_fifo with push, pop, clear, full, empty and occupancy ports.

Verification
REQ-035 Push idx 3 taken, resolve taken -> next cycle upd_valid=1, upd_addr=3, upd_taken=1, mispredict=0, branch_count=1.
REQ-036 Push idx 4/5/6 all not-taken, resolve first as taken -> upd_addr=4, mispredict=1, occupancy 0, pred_ready=0 one cycle then 1, mispred_count=1.
REQ-037 Push 4 entries with DEPTH=4 -> pred_ready=0; pop and push in the same cycle -> push rejected, occupancy 3.
REQ-038 res_valid on an empty FIFO -> res_err=1, no upd_valid, counters unchanged; res_err holds until rst.
REQ-039 Preload branch_count to all ones via 2^CNT_W pops (CNT_W=4 build) -> count stays 15 on further pops.
REQ-040 Assert rst with 2 entries queued and a pop in progress -> all outputs 0 immediately, no upd_valid after release, pred_ready=1.
